vram_rect_fill: RTL and testbench



---
 rtl/vram_rect_fill_if.sv | 30 +++
 rtl/vram_rect_fill.sv | 199 +++++++++++++++++++
 tb/tb_vram_rect_fill.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_rect_fill_if.sv
// Control/status and VRAM port bundle for the rectangle-fill engine.
// The slave side is the engine; the master side is the requester plus the VRAM port.
interface vram_rect_fill_if #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     start;
  logic [8:0]               x0;
  logic [7:0]               y0;
  logic [8:0]               width;
  logic [7:0]               height;
  logic [3:0]               colour;
  logic                     busy;
  logic                     done;
  logic                     vram_enable;
  logic                     vram_rw;
  logic [ADDRESS_WIDTH-1:0] vram_addr;
  logic [WORD_SIZE-1:0]     vram_data_out;
  logic [WORD_SIZE-1:0]     vram_data_in;

  modport slave (
    input  start, x0, y0, width, height, colour, vram_data_in,
    output busy, done, vram_enable, vram_rw, vram_addr, vram_data_out
  );

  modport master (
    output start, x0, y0, width, height, colour, vram_data_in,
    input  busy, done, vram_enable, vram_rw, vram_addr, vram_data_out
  );
endinterface

// File: rtl/vram_rect_fill.sv
// Solid rectangle fill into packed 4bpp VRAM (4 pixels per 16-bit word, 80 words per row).
// Fully covered words are written directly; partially covered words use read-modify-write.
module vram_rect_fill #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter int WORD_SIZE     = 16,
  parameter int PIXEL_BITS    = 4,
  parameter int ADDRESS_WIDTH = 16
) (
  input logic             clock,
  input logic             reset,
  vram_rect_fill_if.slave bus
);
  localparam int PIXELS_PER_WORD = WORD_SIZE / PIXEL_BITS;
  localparam int PIX_SHIFT       = $clog2(PIXELS_PER_WORD);
  localparam int COL_W           = 9 - PIX_SHIFT;
  localparam int WORDS_PER_ROW   = SCREEN_WIDTH / PIXELS_PER_WORD;
  localparam logic [9:0] X_LIMIT     = 10'(SCREEN_WIDTH);
  localparam logic [8:0] Y_LIMIT     = 9'(SCREEN_HEIGHT);
  localparam logic [9:0] WORD_PIXELS = 10'(PIXELS_PER_WORD);
  localparam logic [ADDRESS_WIDTH-1:0] ROW_STRIDE = ADDRESS_WIDTH'(WORDS_PER_ROW);

  typedef enum logic [2:0] {IDLE, SETUP, WORD, RD, MERGE, NEXT, FIN} state_t;

  state_t                     state_q, state_d;
  logic [8:0]                 x0_q, x0_d, width_q, width_d;
  logic [7:0]                 y0_q, y0_d, height_q, height_d;
  logic [PIXEL_BITS-1:0]      colour_q, colour_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [8:0]                 row_q, row_d;
  logic [ADDRESS_WIDTH-1:0]   base_q, base_d;
  logic [PIXELS_PER_WORD-1:0] mask_q, mask_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       en_q, en_d, rw_q, rw_d, merge_q, merge_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]       data_q, data_d;

  // Clip with widened sums so x0+width and y0+height can never wrap.
  logic [9:0] x_sum, x_end;
  logic [8:0] y_sum, y_end;
  logic       empty;

  assign x_sum = {1'b0, x0_q} + {1'b0, width_q};
  assign x_end = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
  assign y_sum = {1'b0, y0_q} + {1'b0, height_q};
  assign y_end = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
  assign empty = (width_q == 9'd0) || (height_q == 8'd0) ||
                 ({1'b0, x0_q} >= X_LIMIT) || ({1'b0, y0_q} >= Y_LIMIT);

  logic [COL_W-1:0]           first_col, step_col, cand_col;
  logic [8:0]                 step_row;
  logic [ADDRESS_WIDTH-1:0]   step_base, cand_base, cand_addr;
  logic [9:0]                 word_end;
  logic                       row_last, rect_last;
  logic [PIXELS_PER_WORD-1:0] cand_mask;
  logic [WORD_SIZE-1:0]       fill_word, merged_word;

  assign first_col = x0_q[8:PIX_SHIFT];
  assign word_end  = {1'b0, col_q, {PIX_SHIFT{1'b0}}} + WORD_PIXELS;
  assign row_last  = (word_end >= x_end);
  assign rect_last = row_last && ((row_q + 9'd1) >= {1'b0, y_end[7:0]} + {y_end[8], 8'd0});
  assign step_col  = row_last ? first_col : col_q + COL_W'(1);
  assign step_row  = row_last ? row_q + 9'd1 : row_q;
  assign step_base = row_last ? base_q + ROW_STRIDE : base_q;

  // The word about to be entered: the first word when leaving SETUP, else the advanced one.
  assign cand_col  = (state_q == SETUP) ? first_col : step_col;
  assign cand_base = (state_q == SETUP) ? ADDRESS_WIDTH'(y0_q) * ROW_STRIDE : step_base;
  assign cand_addr = cand_base + ADDRESS_WIDTH'(cand_col);
  assign fill_word = {PIXELS_PER_WORD{colour_q}};

  generate
    for (genvar gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_nibble
      localparam int HI = WORD_SIZE - 1 - gi * PIXEL_BITS;
      logic [9:0] pix;
      assign pix           = {1'b0, cand_col, PIX_SHIFT'(gi)};
      assign cand_mask[gi] = (pix >= {1'b0, x0_q}) && (pix < x_end);
      assign merged_word[HI -: PIXEL_BITS] =
        mask_q[gi] ? colour_q : bus.vram_data_in[HI -: PIXEL_BITS];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    width_d  = width_q;
    height_d = height_q;
    colour_d = colour_q;
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    mask_d   = mask_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    en_d     = 1'b0;
    rw_d     = 1'b0;
    merge_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d     = bus.x0;
          y0_d     = bus.y0;
          width_d  = bus.width;
          height_d = bus.height;
          colour_d = bus.colour;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP, NEXT: begin
        if ((state_q == SETUP && empty) || (state_q == NEXT && rect_last)) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = WORD;
          col_d   = cand_col;
          row_d   = (state_q == SETUP) ? {1'b0, y0_q} : step_row;
          base_d  = cand_base;
          mask_d  = cand_mask;
          addr_d  = cand_addr;
          if (&cand_mask) begin
            en_d   = 1'b1;
            rw_d   = 1'b1;
            data_d = fill_word;
          end
        end
      end
      WORD: begin
        if (&mask_q) begin
          state_d = NEXT;
        end else begin
          state_d = RD;
          en_d    = 1'b1;
        end
      end
      RD: begin
        state_d = MERGE;
        en_d    = 1'b1;
        rw_d    = 1'b1;
        merge_d = 1'b1;
      end
      MERGE:   state_d = NEXT;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      colour_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      base_q   <= '0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      merge_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      width_q  <= width_d;
      height_q <= height_d;
      colour_q <= colour_d;
      col_q    <= col_d;
      row_q    <= row_d;
      base_q   <= base_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
      merge_q  <= merge_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vram_enable = en_q;
  assign bus.vram_rw     = rw_q;
  assign bus.vram_addr   = addr_q;
  // The merge write carries the read data returning in the same cycle.
  assign bus.vram_data_out = merge_q ? merged_word : data_q;
endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill with a 1-cycle-latency VRAM model and access log.
`timescale 1ns/1ps
module tb_vram_rect_fill;
  localparam int MEM_WORDS = 19200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vram_rect_fill_if bus ();
  vram_rect_fill dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [15:0] mem [0:MEM_WORDS-1];
  logic [15:0] rdata = 16'h0000;
  logic        clr_req = 1'b0;
  logic        poke_we = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [15:0] poke_data = 16'h0000;
  logic        prev_busy = 1'b0;
  int wr_count = 0, rd_count = 0, done_count = 0, bad_addr = 0, overlap = 0, busy_drop = 0;
  int wlog_addr[$];

  assign bus.vram_data_in = rdata;

  always @(posedge clock) begin
    if (clr_req) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 16'h0000;
    end else if (poke_we) begin
      mem[poke_addr] <= poke_data;
    end
    if (bus.vram_enable) begin
      if (int'(bus.vram_addr) >= MEM_WORDS) begin
        bad_addr <= bad_addr + 1;
      end else if (bus.vram_rw) begin
        mem[bus.vram_addr] <= bus.vram_data_out;
        wr_count <= wr_count + 1;
        wlog_addr.push_back(int'(bus.vram_addr));
      end else begin
        rdata    <= mem[bus.vram_addr];
        rd_count <= rd_count + 1;
      end
    end
    if (bus.done) done_count <= done_count + 1;
    if (bus.done && bus.busy) overlap <= overlap + 1;
    if (prev_busy && !bus.busy && !bus.done) busy_drop <= busy_drop + 1;
    prev_busy <= bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mem();
    @(negedge clock); clr_req = 1'b1;
    @(negedge clock); clr_req = 1'b0;
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    @(negedge clock);
    poke_addr = 16'(a); poke_data = d; poke_we = 1'b1;
    @(negedge clock); poke_we = 1'b0;
  endtask

  task automatic launch(input int x, input int y, input int w, input int h, input logic [3:0] c);
    @(negedge clock);
    bus.x0 = 9'(x); bus.y0 = 8'(y); bus.width = 9'(w); bus.height = 8'(h); bus.colour = c;
    bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    tick(2);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({bus.busy, bus.done, bus.vram_enable, bus.vram_rw} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.vram_enable, bus.vram_rw});
    end
    checks++;
    if (bus.vram_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bus.vram_addr); end
    checks++;
    if (bus.vram_data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.vram_data_out); end
    clear_mem();
    @(negedge clock); reset = 1'b1;
    tick(2);
  endtask

  task automatic test_aligned();
    int w0, r0, d0, q0, o0, b0;
    bit seen;
    int exp_a [4] = '{0, 1, 80, 81};
    int chk_a [7] = '{0, 1, 80, 81, 2, 82, 160};
    logic [15:0] chk_d [7] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    clear_mem();
    w0 = wr_count; r0 = rd_count; d0 = done_count; q0 = wlog_addr.size(); o0 = overlap; b0 = busy_drop;
    launch(0, 0, 8, 2, 4'hA);
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL aligned_done_seen: got 0 expected 1"); end
    checks++; if (wr_count - w0 !== 4) begin errors++; $display("FAIL aligned_writes: got %0d expected 4", wr_count - w0); end
    checks++; if (rd_count - r0 !== 0) begin errors++; $display("FAIL aligned_reads: got %0d expected 0", rd_count - r0); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL aligned_done_count: got %0d expected 1", done_count - d0); end
    checks++; if (overlap - o0 !== 0) begin errors++; $display("FAIL aligned_busy_with_done: got %0d expected 0", overlap - o0); end
    checks++; if (busy_drop - b0 !== 0) begin errors++; $display("FAIL aligned_busy_drop: got %0d expected 0", busy_drop - b0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wlog_addr.size() <= q0 + k || wlog_addr[q0 + k] !== exp_a[k]) begin
        errors++; $display("FAIL aligned_order[%0d]: log size %0d expected addr %0d", k, wlog_addr.size() - q0, exp_a[k]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (mem[chk_a[k]] !== chk_d[k]) begin
        errors++; $display("FAIL aligned_mem[%0d]: got %h expected %h", chk_a[k], mem[chk_a[k]], chk_d[k]);
      end
    end
  endtask

  task automatic test_unaligned();
    int w0, r0, d0;
    bit seen;
    clear_mem();
    poke(800, 16'hBEEF); poke(801, 16'h1234); poke(802, 16'hCAFE);
    w0 = wr_count; r0 = rd_count; d0 = done_count;
    launch(5, 10, 2, 1, 4'h3);
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL unaligned_done_seen: got 0 expected 1"); end
    checks++; if (rd_count - r0 !== 1) begin errors++; $display("FAIL unaligned_reads: got %0d expected 1", rd_count - r0); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL unaligned_writes: got %0d expected 1", wr_count - w0); end
    checks++; if (mem[801] !== 16'h1334) begin errors++; $display("FAIL unaligned_801: got %h expected 1334", mem[801]); end
    checks++; if (mem[800] !== 16'hBEEF) begin errors++; $display("FAIL unaligned_800: got %h expected beef", mem[800]); end
    checks++; if (mem[802] !== 16'hCAFE) begin errors++; $display("FAIL unaligned_802: got %h expected cafe", mem[802]); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL unaligned_done_count: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_clip();
    int w0, r0, a0;
    bit seen;
    clear_mem();
    poke(19198, 16'h1111);
    w0 = wr_count; r0 = rd_count; a0 = bad_addr;
    launch(318, 239, 10, 5, 4'hF);
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL clip_done_seen: got 0 expected 1"); end
    checks++; if (rd_count - r0 !== 1) begin errors++; $display("FAIL clip_reads: got %0d expected 1", rd_count - r0); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL clip_writes: got %0d expected 1", wr_count - w0); end
    checks++; if (bad_addr - a0 !== 0) begin errors++; $display("FAIL clip_out_of_range: got %0d expected 0", bad_addr - a0); end
    checks++; if (mem[19199] !== 16'h00FF) begin errors++; $display("FAIL clip_19199: got %h expected 00ff", mem[19199]); end
    checks++; if (mem[19198] !== 16'h1111) begin errors++; $display("FAIL clip_19198: got %h expected 1111", mem[19198]); end
  endtask

  task automatic test_degenerate();
    int xs [2] = '{10, 320};
    int ws [2] = '{0, 4};
    for (int c = 0; c < 2; c++) begin
      int acc0, d0, lat;
      acc0 = wr_count + rd_count + bad_addr; d0 = done_count;
      @(negedge clock);
      bus.x0 = 9'(xs[c]); bus.y0 = 8'd10; bus.width = 9'(ws[c]); bus.height = 8'd3; bus.colour = 4'h5;
      bus.start = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock);
        bus.start = 1'b0;
        if (bus.done) begin lat = k; break; end
      end
      tick(3);
      checks++; if (lat !== 2) begin errors++; $display("FAIL degenerate%0d_latency: got %0d expected 2", c, lat); end
      checks++;
      if (wr_count + rd_count + bad_addr - acc0 !== 0) begin
        errors++; $display("FAIL degenerate%0d_access: got %0d expected 0", c, wr_count + rd_count + bad_addr - acc0);
      end
      checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL degenerate%0d_done_count: got %0d expected 1", c, done_count - d0); end
    end
  endtask

  task automatic test_ignore_busy();
    int w0, d0;
    bit seen;
    clear_mem();
    w0 = wr_count; d0 = done_count;
    launch(0, 0, 16, 4, 4'h7);
    tick(3);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_state: got %b expected 1", bus.busy); end
    launch(0, 0, 4, 1, 4'h1);
    wait_done(400, seen);
    tick(20);
    checks++; if (!seen) begin errors++; $display("FAIL ignore_done_seen: got 0 expected 1"); end
    checks++; if (wr_count - w0 !== 16) begin errors++; $display("FAIL ignore_writes: got %0d expected 16", wr_count - w0); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_count - d0); end
    checks++; if (mem[0] !== 16'h7777) begin errors++; $display("FAIL ignore_mem0: got %h expected 7777", mem[0]); end
    checks++; if (mem[243] !== 16'h7777) begin errors++; $display("FAIL ignore_mem243: got %h expected 7777", mem[243]); end
    checks++; if (mem[4] !== 16'h0000) begin errors++; $display("FAIL ignore_mem4: got %h expected 0000", mem[4]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    int w0, d0;
    bit found, seen;
    clear_mem();
    w0 = wr_count; d0 = done_count;
    launch(0, 0, 8, 4, 4'hC);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.vram_enable && bus.vram_rw && (wr_count - w0 == 2)) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_third_write: got 0 expected 1"); end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.vram_enable, bus.vram_rw} !== 4'b0000 || bus.vram_addr !== 16'h0000 || bus.vram_data_out !== 16'h0000) begin
      errors++; $display("FAIL midreset_outputs: got ctrl %b addr %h data %h expected all zero",
                         {bus.busy, bus.done, bus.vram_enable, bus.vram_rw}, bus.vram_addr, bus.vram_data_out);
    end
    tick(5);
    reset = 1'b1;
    tick(10);
    checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL midreset_writes: got %0d expected 2", wr_count - w0); end
    checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL midreset_done: got %0d expected 0", done_count - d0); end
    checks++; if (mem[1] !== 16'hCCCC) begin errors++; $display("FAIL midreset_mem1: got %h expected cccc", mem[1]); end
    checks++; if (mem[80] !== 16'h0000) begin errors++; $display("FAIL midreset_mem80: got %h expected 0000", mem[80]); end
    d0 = done_count;
    launch(0, 5, 4, 1, 4'h9);
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL midreset_restart_done: got 0 expected 1"); end
    checks++; if (mem[400] !== 16'h9999) begin errors++; $display("FAIL midreset_mem400: got %h expected 9999", mem[400]); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL midreset_restart_count: got %0d expected 1", done_count - d0); end
  endtask

  initial begin
    bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.width = '0; bus.height = '0; bus.colour = '0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_clip();
    test_degenerate();
    test_ignore_busy();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
